// File: rtl/hall_pkg.sv
// Shared Hall-sensor constants, sequence helpers and edge classification
// for the Hall decoder.
package hall_pkg;

    localparam logic [2:0] HALL_INV_LO = 3'b000;
    localparam logic [2:0] HALL_INV_HI = 3'b111;

    // Forward commutation order 1,3,2,6,4,5 packed LSB-first, three bits per step.
    localparam logic [17:0] HALL_FWD_SEQ = {3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1};

    typedef enum logic [2:0] {
        EvNone,
        EvInvalid,
        EvFirst,
        EvFwd,
        EvRev,
        EvSkip
    } hall_ev_e;

    function automatic logic is_valid(input logic [2:0] code);
        return (code != HALL_INV_LO) && (code != HALL_INV_HI);
    endfunction

    function automatic logic [2:0] fwd_next(input logic [2:0] code);
        logic [2:0] nxt;
        nxt = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (HALL_FWD_SEQ[3*i +: 3] == code) begin
                nxt = HALL_FWD_SEQ[3*((i + 1) % 6) +: 3];
            end
        end
        return nxt;
    endfunction

    function automatic logic [2:0] rev_next(input logic [2:0] code);
        logic [2:0] nxt;
        nxt = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (HALL_FWD_SEQ[3*i +: 3] == code) begin
                nxt = HALL_FWD_SEQ[3*((i + 5) % 6) +: 3];
            end
        end
        return nxt;
    endfunction

    function automatic hall_ev_e classify(input logic [2:0] old_code,
                                          input logic [2:0] new_code);
        if (!is_valid(new_code)) return EvInvalid;
        if (!is_valid(old_code)) return EvFirst;
        if (new_code == fwd_next(old_code)) return EvFwd;
        if (new_code == rev_next(old_code)) return EvRev;
        return EvSkip;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchroniser and FILT_LEN-sample debounce for the raw Hall lines;
// emits the accepted code, the current candidate and a one-cycle accept strobe.
module hall_filter
    import hall_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall_i,
    output logic [2:0] code_o,
    output logic [2:0] cand_o,
    output logic       accept_o
);

    localparam logic [7:0] Thresh = 8'(FILT_LEN);

    logic [2:0] meta_q, sync_q, last_q;
    logic [2:0] code_q, code_d;
    logic [7:0] stab_q, stab_d;
    logic       accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 3'd0;
            sync_q <= 3'd0;
            last_q <= 3'd0;
            stab_q <= 8'd0;
            code_q <= 3'd0;
        end else begin
            meta_q <= hall_i;
            sync_q <= meta_q;
            last_q <= sync_q;
            stab_q <= stab_d;
            code_q <= code_d;
        end
    end

    // stab_d counts how many cycles sync_q has held its present value, this one included.
    always_comb begin
        if (sync_q != last_q) begin
            stab_d = 8'd1;
        end else if (stab_q == 8'hFF) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + 8'd1;
        end
        accept = (sync_q != code_q) && (stab_d >= Thresh);
        code_d = accept ? sync_q : code_q;
    end

    assign code_o   = code_q;
    assign cand_o   = sync_q;
    assign accept_o = accept;

endmodule

// File: rtl/hall_decoder.sv
// Hall decoder: sequence checking, direction, electrical position and edge period.
// Optional HALL_PERIOD_AVG_EN reports the mean of the last four legal periods.
module hall_decoder
    import hall_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned PER_W    = 24,
    parameter int unsigned POS_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       hall_in,
    input  logic             clr_pos,
    output logic [2:0]       hall_out,
    output logic             hall_valid,
    output logic             dir,
    output logic             edge_pulse,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             stalled,
    output logic             fault,
    output logic [POS_W-1:0] position
);

    localparam logic [PER_W-1:0] CntOne = PER_W'(1);
    localparam logic [PER_W-1:0] CntMax = '1;
    localparam logic [POS_W-1:0] PosOne = POS_W'(1);

    logic [2:0] code, cand;
    logic       accept;

    hall_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .hall_i   (hall_in),
        .code_o   (code),
        .cand_o   (cand),
        .accept_o (accept)
    );

    logic             dir_q, dir_d;
    logic             edge_q;
    logic             fault_q, fault_d;
    logic             pv_q, pv_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             stalled_q, stalled_d;
    logic             ref_ok_q, ref_ok_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             cnt_sat;
    logic             raw_pv;
    hall_ev_e         ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= 1'b1;
            edge_q    <= 1'b0;
            fault_q   <= 1'b0;
            pv_q      <= 1'b0;
            period_q  <= '0;
            stalled_q <= 1'b1;
            ref_ok_q  <= 1'b0;
            cnt_q     <= '0;
            pos_q     <= '0;
        end else begin
            dir_q     <= dir_d;
            edge_q    <= accept;
            fault_q   <= fault_d;
            pv_q      <= pv_d;
            period_q  <= period_d;
            stalled_q <= stalled_d;
            ref_ok_q  <= ref_ok_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
        end
    end

    always_comb begin
        ev        = accept ? classify(code, cand) : EvNone;
        cnt_sat   = (cnt_q == CntMax);
        dir_d     = dir_q;
        fault_d   = 1'b0;
        pos_d     = pos_q;
        raw_pv    = 1'b0;
        cnt_d     = cnt_sat ? cnt_q : cnt_q + CntOne;
        stalled_d = stalled_q | cnt_sat;
        ref_ok_d  = ref_ok_q & ~cnt_sat;

        unique case (ev)
            EvInvalid: begin
                fault_d   = 1'b1;
                ref_ok_d  = 1'b0;
                stalled_d = 1'b1;
            end
            EvFirst: begin
                cnt_d = CntOne;
            end
            EvFwd, EvRev: begin
                dir_d     = (ev == EvFwd);
                pos_d     = (ev == EvFwd) ? pos_q + PosOne : pos_q - PosOne;
                // A saturating counter this very cycle already disqualifies the period.
                raw_pv    = ref_ok_q && !stalled_q && !cnt_sat;
                ref_ok_d  = 1'b1;
                stalled_d = 1'b0;
                cnt_d     = CntOne;
            end
            EvSkip: begin
                fault_d   = 1'b1;
                ref_ok_d  = 1'b0;
                stalled_d = 1'b1;
                cnt_d     = CntOne;
            end
            default: ;
        endcase

        if (clr_pos) begin
            pos_d = '0;
        end
    end

`ifdef HALL_PERIOD_AVG_EN
    logic [PER_W-1:0] hist_q [4];
    logic [PER_W-1:0] hist_d [4];
    logic [PER_W+1:0] sum_q, sum_d;
    logic [2:0]       fill_q, fill_d;
    logic             flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            sum_q  <= '0;
            fill_q <= 3'd0;
        end else begin
            for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end

    // Flushed entries read as zero, so subtracting hist_q[3] is safe while filling.
    always_comb begin
        flush    = cnt_sat || (ev == EvInvalid) || (ev == EvSkip);
        for (int i = 0; i < 4; i++) hist_d[i] = hist_q[i];
        sum_d    = sum_q;
        fill_d   = fill_q;
        pv_d     = 1'b0;
        period_d = period_q;
        if (flush) begin
            for (int i = 0; i < 4; i++) hist_d[i] = '0;
            sum_d  = '0;
            fill_d = 3'd0;
        end else if (raw_pv) begin
            hist_d[0] = cnt_q;
            for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
            sum_d  = sum_q + {2'b00, cnt_q} - {2'b00, hist_q[3]};
            fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
            if (fill_d == 3'd4) begin
                pv_d     = 1'b1;
                period_d = sum_d[PER_W+1:2];
            end
        end
    end
`else
    always_comb begin
        pv_d     = raw_pv;
        period_d = raw_pv ? cnt_q : period_q;
    end
`endif

    assign hall_out     = code;
    assign hall_valid   = is_valid(code);
    assign dir          = dir_q;
    assign edge_pulse   = edge_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign stalled      = stalled_q;
    assign fault        = fault_q;
    assign position     = pos_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Directed, table-driven bench for hall_decoder (default build, PER_W=8 so
// the period counter saturates within a short dwell).
module tb_hall_decoder;

    localparam int unsigned FILT_LEN = 4;
    localparam int unsigned PER_W    = 8;
    localparam int unsigned POS_W    = 16;
    localparam int          NVEC     = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       hall_in = 3'd0;
    logic             clr_pos = 1'b0;
    logic [2:0]       hall_out;
    logic             hall_valid;
    logic             dir;
    logic             edge_pulse;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             stalled;
    logic             fault;
    logic [POS_W-1:0] position;

    hall_decoder #(
        .FILT_LEN (FILT_LEN),
        .PER_W    (PER_W),
        .POS_W    (POS_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hall_in      (hall_in),
        .clr_pos      (clr_pos),
        .hall_out     (hall_out),
        .hall_valid   (hall_valid),
        .dir          (dir),
        .edge_pulse   (edge_pulse),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .fault        (fault),
        .position     (position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  hall;
        int          dwell;
        bit          clr;
        bit          glitch;
        logic [2:0]  e_out;
        bit          e_valid;
        bit          e_dir;
        logic [15:0] e_pos;
        bit          e_pv;
        logic [7:0]  e_per;
        bit          e_fault;
        bit          e_stall;
        bit          e_stall_end;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " hall_out"}, 32'(hall_out), 32'd0);
        check({tag, " hall_valid"}, 32'(hall_valid), 32'd0);
        check({tag, " dir"}, 32'(dir), 32'd1);
        check({tag, " edge_pulse"}, 32'(edge_pulse), 32'd0);
        check({tag, " period"}, 32'(period), 32'd0);
        check({tag, " period_valid"}, 32'(period_valid), 32'd0);
        check({tag, " stalled"}, 32'(stalled), 32'd1);
        check({tag, " fault"}, 32'(fault), 32'd0);
        check({tag, " position"}, 32'(position), 32'd0);
    endtask

    initial begin
        logic [2:0] prev;
        int         used;
        string      t;

        //          hall  dwl  clr gl  out v dir pos      pv per   f st se
        vecs[0]  = '{3'd1, 100, 0, 0, 3'd1, 1, 1, 16'h0000, 0, 8'd0,   0, 1, 1};
        vecs[1]  = '{3'd3, 100, 0, 0, 3'd3, 1, 1, 16'h0001, 0, 8'd0,   0, 0, 0};
        vecs[2]  = '{3'd2, 100, 0, 0, 3'd2, 1, 1, 16'h0002, 1, 8'd100, 0, 0, 0};
        vecs[3]  = '{3'd6, 100, 0, 0, 3'd6, 1, 1, 16'h0003, 1, 8'd100, 0, 0, 0};
        vecs[4]  = '{3'd4, 100, 0, 0, 3'd4, 1, 1, 16'h0004, 1, 8'd100, 0, 0, 0};
        vecs[5]  = '{3'd5, 100, 0, 0, 3'd5, 1, 1, 16'h0005, 1, 8'd100, 0, 0, 0};
        vecs[6]  = '{3'd1, 100, 0, 0, 3'd1, 1, 1, 16'h0006, 1, 8'd100, 0, 0, 0};
        vecs[7]  = '{3'd5, 100, 0, 0, 3'd5, 1, 0, 16'h0005, 1, 8'd100, 0, 0, 0};
        vecs[8]  = '{3'd4, 100, 0, 1, 3'd4, 1, 0, 16'h0004, 1, 8'd100, 0, 0, 0};
        vecs[9]  = '{3'd5, 100, 0, 0, 3'd5, 1, 1, 16'h0005, 1, 8'd100, 0, 0, 0};
        vecs[10] = '{3'd1, 100, 0, 0, 3'd1, 1, 1, 16'h0006, 1, 8'd100, 0, 0, 0};
        vecs[11] = '{3'd3, 100, 0, 0, 3'd3, 1, 1, 16'h0007, 1, 8'd100, 0, 0, 0};
        vecs[12] = '{3'd6, 100, 0, 0, 3'd6, 1, 1, 16'h0007, 0, 8'd100, 1, 1, 1};
        vecs[13] = '{3'd4, 100, 0, 0, 3'd4, 1, 1, 16'h0008, 0, 8'd100, 0, 0, 0};
        vecs[14] = '{3'd5, 100, 0, 0, 3'd5, 1, 1, 16'h0009, 1, 8'd100, 0, 0, 0};
        vecs[15] = '{3'd1, 100, 1, 0, 3'd1, 1, 1, 16'h0000, 1, 8'd100, 0, 0, 0};
        vecs[16] = '{3'd5, 300, 0, 0, 3'd5, 1, 0, 16'hFFFF, 1, 8'd100, 0, 0, 1};
        vecs[17] = '{3'd4, 57,  0, 0, 3'd4, 1, 0, 16'hFFFE, 0, 8'd100, 0, 0, 0};
        vecs[18] = '{3'd6, 100, 0, 0, 3'd6, 1, 0, 16'hFFFD, 1, 8'd57,  0, 0, 0};
        vecs[19] = '{3'd0, 100, 0, 0, 3'd0, 0, 0, 16'hFFFD, 0, 8'd57,  1, 1, 1};
        vecs[20] = '{3'd2, 100, 0, 0, 3'd2, 1, 0, 16'hFFFD, 0, 8'd57,  0, 1, 1};
        vecs[21] = '{3'd6, 80,  0, 0, 3'd6, 1, 1, 16'hFFFE, 0, 8'd57,  0, 0, 0};
        vecs[22] = '{3'd2, 100, 0, 0, 3'd2, 1, 0, 16'hFFFD, 1, 8'd80,  0, 0, 0};
        vecs[23] = '{3'd3, 100, 0, 0, 3'd3, 1, 0, 16'hFFFC, 1, 8'd100, 0, 0, 0};

        #12;
        check_reset("reset");
        step(1);
        rst  = 1'b0;
        prev = 3'd0;

        for (int i = 0; i < NVEC; i++) begin
            hall_in = vecs[i].hall;
            step(FILT_LEN + 1);
            t = $sformatf("v%0d", i);
            check({t, " pre hall_out"}, 32'(hall_out), 32'(prev));
            check({t, " pre edge"}, 32'(edge_pulse), 32'd0);
            if (vecs[i].clr) clr_pos = 1'b1;
            step(1);
            clr_pos = 1'b0;
            check({t, " hall_out"}, 32'(hall_out), 32'(vecs[i].e_out));
            check({t, " hall_valid"}, 32'(hall_valid), 32'(vecs[i].e_valid));
            check({t, " edge"}, 32'(edge_pulse), 32'd1);
            check({t, " dir"}, 32'(dir), 32'(vecs[i].e_dir));
            check({t, " position"}, 32'(position), 32'(vecs[i].e_pos));
            check({t, " period_valid"}, 32'(period_valid), 32'(vecs[i].e_pv));
            check({t, " period"}, 32'(period), 32'(vecs[i].e_per));
            check({t, " fault"}, 32'(fault), 32'(vecs[i].e_fault));
            check({t, " stalled"}, 32'(stalled), 32'(vecs[i].e_stall));
            used = FILT_LEN + 2;
            step(1);
            check({t, " edge one-shot"}, 32'(edge_pulse), 32'd0);
            check({t, " fault one-shot"}, 32'(fault), 32'd0);
            used++;
            if (vecs[i].glitch) begin
                // Two-cycle excursion to an illegal code must be swallowed silently.
                step(20);
                hall_in = 3'd7;
                step(2);
                hall_in = vecs[i].hall;
                for (int k = 0; k < 12; k++) begin
                    step(1);
                    check({t, " glitch edge"}, 32'(edge_pulse), 32'd0);
                    check({t, " glitch fault"}, 32'(fault), 32'd0);
                    check({t, " glitch hall_out"}, 32'(hall_out), 32'(vecs[i].e_out));
                end
                used += 34;
            end
            step(vecs[i].dwell - used);
            check({t, " stalled end"}, 32'(stalled), 32'(vecs[i].e_stall_end));
            prev = vecs[i].e_out;
        end

        // Asynchronous reset mid-operation clears every output without a clock edge.
        hall_in = 3'd1;
        step(3);
        #2;
        rst = 1'b1;
        #1;
        check_reset("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
